cpu_control_fsm: RTL and testbench

Instruction sequencer and decoder that drives the control inputs of alu_and_reg, replacing the hand-written stimulus used to exercise it.
- Fetches 16-bit instructions from a synchronous instruction memory.
- Decodes each instruction into aluOp / RegEn / BufEnA / BufEnB / imm / immEn / cin.
- Latches ALU flags after flag-setting instructions and resolves conditional branches from those latched flags.
- Together with alu_and_reg it forms the datapath core.

---
 rtl/cpu_control_fsm_if.sv | 29 ++
 rtl/cpu_control_fsm.sv | 157 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Control/bus bundle between the instruction sequencer, its instruction memory
// and the alu_and_reg datapath. master = sequencer side, slave = memory/datapath side.
interface cpu_control_fsm_if #(
    parameter int PC_W = 16
);
    logic            run;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [4:0]      flags;
    logic [7:0]      aluOp;
    logic [4:0]      RegEn;
    logic [4:0]      BufEnA;
    logic [4:0]      BufEnB;
    logic [15:0]     imm;
    logic            immEn;
    logic            cin;
    logic            halted;
    logic [PC_W-1:0] pc;

    modport master (
        input  run, imem_data, flags,
        output imem_addr, aluOp, RegEn, BufEnA, BufEnB, imm, immEn, cin, halted, pc
    );

    modport slave (
        output run, imem_data, flags,
        input  imem_addr, aluOp, RegEn, BufEnA, BufEnB, imm, immEn, cin, halted, pc
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Three-cycle FETCH/DECODE/EXEC sequencer that decodes 16-bit instructions into
// alu_and_reg control inputs and resolves conditional branches on latched flags.
module cpu_control_fsm #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    cpu_control_fsm_if.master   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [4:0]      NO_REG = 5'd16;
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [2:0]      state;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir;
    logic [4:0]      flag_q;

    logic [3:0]      op, rd, ext, rs;
    logic [15:0]     imm_zext, imm_sext;
    logic [PC_W-1:0] disp;
    logic            sets_flags;
    logic            cond_ok;
    logic            flags_unused;

    assign op       = ir[15:12];
    assign rd       = ir[11:8];
    assign ext      = ir[7:4];
    assign rs       = ir[3:0];
    assign imm_zext = {8'h00, ir[7:0]};
    assign imm_sext = {{8{ir[7]}}, ir[7:0]};
    assign disp     = {{(PC_W-8){ir[7]}}, ir[7:0]};

    // L and F are latched for completeness but no branch condition reads them.
    assign flags_unused = ^flag_q[2:1];

    assign sets_flags = (op == 4'h0 && (ext == 4'h5 || ext == 4'h9 || ext == 4'hB)) ||
                        op == 4'h5 || op == 4'h9 || op == 4'hB;

    always_comb begin
        case (rd)
            4'h0:    cond_ok = flag_q[3];
            4'h1:    cond_ok = !flag_q[3];
            4'h2:    cond_ok = flag_q[0];
            4'h3:    cond_ok = !flag_q[0];
            4'h4:    cond_ok = flag_q[4];
            4'h5:    cond_ok = !flag_q[4];
            4'hE:    cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // NOTE: every output gets its idle value first, so no path through the case leaves a latch.
    always_comb begin
        bus.aluOp  = 8'h00;
        bus.RegEn  = NO_REG;
        bus.BufEnA = NO_REG;
        bus.BufEnB = NO_REG;
        bus.imm    = 16'h0000;
        bus.immEn  = 1'b0;
        if (state == S_EXEC) begin
            case (op)
                4'h0: begin
                    case (ext)
                        4'h1, 4'h2, 4'h3, 4'h5, 4'h9: begin
                            bus.aluOp  = {4'h0, ext};
                            bus.RegEn  = {1'b0, rd};
                            bus.BufEnA = {1'b0, rd};
                            bus.BufEnB = {1'b0, rs};
                        end
                        4'hB: begin
                            bus.aluOp  = 8'h09;
                            bus.BufEnA = {1'b0, rd};
                            bus.BufEnB = {1'b0, rs};
                        end
                        4'hD: begin
                            bus.aluOp  = 8'h02;
                            bus.RegEn  = {1'b0, rd};
                            bus.BufEnA = {1'b0, rs};
                            bus.BufEnB = {1'b0, rs};
                        end
                        default: ;
                    endcase
                end
                4'h1, 4'h2, 4'h3: begin
                    bus.aluOp  = {4'h0, op};
                    bus.RegEn  = {1'b0, rd};
                    bus.BufEnA = {1'b0, rd};
                    bus.imm    = imm_zext;
                    bus.immEn  = 1'b1;
                end
                4'h5, 4'h9: begin
                    bus.aluOp  = {4'h0, op};
                    bus.RegEn  = {1'b0, rd};
                    bus.BufEnA = {1'b0, rd};
                    bus.imm    = imm_sext;
                    bus.immEn  = 1'b1;
                end
                4'hB: begin
                    bus.aluOp  = 8'h09;
                    bus.BufEnA = {1'b0, rd};
                    bus.imm    = imm_sext;
                    bus.immEn  = 1'b1;
                end
                4'hD: begin
                    bus.aluOp  = 8'h05;
                    bus.RegEn  = {1'b0, rd};
                    bus.imm    = imm_sext;
                    bus.immEn  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            pc_q   <= RESET_PC;
            ir     <= 16'h0000;
            flag_q <= 5'b00000;
        end else begin
            case (state)
                S_IDLE:   if (bus.run) state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir    <= bus.imem_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == 4'hF) begin
                        state <= S_HALT;
                    end else begin
                        // Branches test the flags latched by an earlier instruction, never the live bus.
                        if (op == 4'hC && cond_ok) pc_q <= pc_q + disp;
                        else                       pc_q <= pc_q + PC_ONE;
                        if (sets_flags) flag_q <= bus.flags;
                        state <= bus.run ? S_FETCH : S_IDLE;
                    end
                end
                S_HALT:   state <= S_HALT;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.cin       = 1'b0;
    assign bus.halted    = (state == S_HALT);
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed instruction table, multi-cycle corner cases
// (wrap, halt, async reset, run drop) and random programs against a reference model.
module tb_cpu_control_fsm;
    typedef struct packed {
        logic [7:0]  aluop;
        logic [4:0]  regen;
        logic [4:0]  bufa;
        logic [4:0]  bufb;
        logic [15:0] imm;
        logic        immen;
        logic        cin;
    } ctrl_t;

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  fl;
        ctrl_t       exp_c;
        logic [15:0] exp_pc;
    } vec_t;

    localparam ctrl_t IDLE_C = '{8'h00, 5'd16, 5'd16, 5'd16, 16'h0000, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem [0:65535];
    logic [15:0] cur_pc;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    cpu_control_fsm_if #(.PC_W(16)) bus ();

    cpu_control_fsm #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

    function automatic ctrl_t sample();
        return ctrl_t'({bus.aluOp, bus.RegEn, bus.BufEnA, bus.BufEnB, bus.imm, bus.immEn, bus.cin});
    endfunction

    function automatic ctrl_t mkc(logic [7:0] a, logic [4:0] r, logic [4:0] ba, logic [4:0] bb,
                                  logic [15:0] i, logic ie);
        return '{a, r, ba, bb, i, ie, 1'b0};
    endfunction

    function automatic vec_t mkv(logic [15:0] instr, logic [4:0] fl, ctrl_t c, logic [15:0] npc);
        vec_t v;
        v.instr = instr; v.fl = fl; v.exp_c = c; v.exp_pc = npc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @pc_exp=%04h: got %0h expected %0h", name, cur_pc, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.run = 1'b0;
        bus.flags = 5'b0;
        reset = 1'b1;
        @(negedge clk);
        check("reset_ctrl", sample(), IDLE_C);
        check("reset_pc", bus.pc, 16'h0000);
        check("reset_halted", bus.halted, 1'b0);
        reset = 1'b0;
        cur_pc = 16'h0000;
        @(negedge clk);
    endtask

    // Leaves the DUT in FETCH at a falling edge.
    task automatic start();
        bus.run = 1'b1;
        @(negedge clk);
    endtask

    // Entered in FETCH; returns at the next FETCH (or IDLE when run is low).
    task automatic step(input logic [15:0] instr, input logic [4:0] fl, input ctrl_t exp_c,
                        input logic [15:0] exp_pc, input string name);
        mem[cur_pc] = instr;
        @(negedge clk);
        check({name, "_decode_idle"}, sample(), IDLE_C);
        bus.flags = fl;
        @(negedge clk);
        check({name, "_exec_ctrl"}, sample(), exp_c);
        @(negedge clk);
        check({name, "_next_pc"}, bus.pc, exp_pc);
        cur_pc = exp_pc;
    endtask

    // Reference model, written from the instruction-set rules.
    function automatic bit is_alu_code(logic [3:0] c);
        return c inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    endfunction

    function automatic ctrl_t ref_ctrl(logic [15:0] ir);
        ctrl_t c = IDLE_C;
        logic [3:0] op = ir[15:12], rd = ir[11:8], ext = ir[7:4], rs = ir[3:0];
        logic [3:0] code;
        bit reg_form = (op == 4'h0) && is_alu_code(ext);
        bit imm_form = is_alu_code(op);
        if (!reg_form && !imm_form) return c;
        code    = reg_form ? ext : op;
        c.aluop = (code == 4'hB) ? 8'h09 : (code == 4'hD) ? (reg_form ? 8'h02 : 8'h05) : {4'h0, code};
        c.regen = (code == 4'hB) ? 5'd16 : {1'b0, rd};
        if (reg_form) begin
            c.bufa = (code == 4'hD) ? {1'b0, rs} : {1'b0, rd};
            c.bufb = {1'b0, rs};
        end else begin
            c.bufa  = (code == 4'hD) ? 5'd16 : {1'b0, rd};
            c.immen = 1'b1;
            c.imm   = (code <= 4'h3) ? {8'h00, ir[7:0]} : {{8{ir[7]}}, ir[7:0]};
        end
        return c;
    endfunction

    function automatic bit ref_sets_flags(logic [15:0] ir);
        logic [3:0] code = (ir[15:12] == 4'h0) ? ir[7:4] : ir[15:12];
        return code inside {4'h5, 4'h9, 4'hB} && (ir[15:12] == 4'h0 || ir[15:12] == code);
    endfunction

    function automatic bit ref_taken(logic [3:0] cond, logic [4:0] fq);
        int flag_bit [3] = '{3, 0, 4};
        if (cond == 4'hE) return 1'b1;
        if (cond > 4'h5) return 1'b0;
        return fq[flag_bit[cond / 2]] ^ cond[0];
    endfunction

    function automatic logic [15:0] ref_next_pc(logic [15:0] ir, logic [15:0] pc, logic [4:0] fq);
        if (ir[15:12] == 4'hF) return pc;
        if (ir[15:12] == 4'hC && ref_taken(ir[11:8], fq)) return pc + {{8{ir[7]}}, ir[7:0]};
        return pc + 16'd1;
    endfunction

    logic [3:0] rand_ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE};
    logic [3:0] rand_ext [8]  = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'h7};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [23];
        logic [15:0] instr;
        logic [4:0]  fl, mfq;
        logic [3:0]  op;
        logic [15:0] npc;

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        bus.run   = 1'b0;
        bus.flags = 5'b0;
        cur_pc    = 16'h0000;

        tbl[0]  = mkv(16'h5012, 5'b00000, mkc(8'h05, 5'd0,  5'd0,  5'd16, 16'h0012, 1'b1), 16'd1);
        tbl[1]  = mkv(16'h51FF, 5'b00000, mkc(8'h05, 5'd1,  5'd1,  5'd16, 16'hFFFF, 1'b1), 16'd2);
        tbl[2]  = mkv(16'h00D1, 5'b00000, mkc(8'h02, 5'd0,  5'd1,  5'd1,  16'h0000, 1'b0), 16'd3);
        tbl[3]  = mkv(16'h01B2, 5'b01000, mkc(8'h09, 5'd16, 5'd1,  5'd2,  16'h0000, 1'b0), 16'd4);
        tbl[4]  = mkv(16'h0000, 5'b00000, IDLE_C, 16'd5);
        tbl[5]  = mkv(16'hC003, 5'b00000, IDLE_C, 16'd8);
        tbl[6]  = mkv(16'h0152, 5'b00000, mkc(8'h05, 5'd1,  5'd1,  5'd2,  16'h0000, 1'b0), 16'd9);
        tbl[7]  = mkv(16'hC003, 5'b01000, IDLE_C, 16'd10);
        tbl[8]  = mkv(16'h1A8F, 5'b01000, mkc(8'h01, 5'd10, 5'd10, 5'd16, 16'h008F, 1'b1), 16'd11);
        tbl[9]  = mkv(16'hC103, 5'b01000, IDLE_C, 16'd14);
        tbl[10] = mkv(16'h2380, 5'b00000, mkc(8'h02, 5'd3,  5'd3,  5'd16, 16'h0080, 1'b1), 16'd15);
        tbl[11] = mkv(16'h3C80, 5'b00000, mkc(8'h03, 5'd12, 5'd12, 5'd16, 16'h0080, 1'b1), 16'd16);
        tbl[12] = mkv(16'h9401, 5'b00001, mkc(8'h09, 5'd4,  5'd4,  5'd16, 16'h0001, 1'b1), 16'd17);
        tbl[13] = mkv(16'hC202, 5'b00000, IDLE_C, 16'd19);
        tbl[14] = mkv(16'hB7FE, 5'b10000, mkc(8'h09, 5'd16, 5'd7,  5'd16, 16'hFFFE, 1'b1), 16'd20);
        tbl[15] = mkv(16'hC4FE, 5'b00000, IDLE_C, 16'd18);
        tbl[16] = mkv(16'hD6F0, 5'b00000, mkc(8'h05, 5'd6,  5'd16, 5'd16, 16'hFFF0, 1'b1), 16'd19);
        tbl[17] = mkv(16'hC500, 5'b00000, IDLE_C, 16'd20);
        tbl[18] = mkv(16'h0093, 5'b00000, mkc(8'h09, 5'd0,  5'd0,  5'd3,  16'h0000, 1'b0), 16'd21);
        tbl[19] = mkv(16'h0041, 5'b11111, IDLE_C, 16'd22);
        tbl[20] = mkv(16'h4123, 5'b00000, IDLE_C, 16'd23);
        tbl[21] = mkv(16'hC705, 5'b00000, IDLE_C, 16'd24);
        tbl[22] = mkv(16'hC3FA, 5'b00000, IDLE_C, 16'd18);

        do_reset();
        start();
        foreach (tbl[i]) step(tbl[i].instr, tbl[i].fl, tbl[i].exp_c, tbl[i].exp_pc, "tbl");

        // Backward branch wrapping below zero, then pc+1 wrapping past 0xFFFF.
        do_reset();
        start();
        step(16'hCEFF, 5'b00000, IDLE_C, 16'hFFFF, "wrap_branch");
        step(16'h0000, 5'b00000, IDLE_C, 16'h0000, "wrap_nop");

        // HALT at pc=4 holds while run stays high.
        do_reset();
        start();
        for (int i = 0; i < 4; i++) step(16'h0000, 5'b00000, IDLE_C, 16'(i + 1), "pre_halt");
        step(16'hF000, 5'b00000, IDLE_C, 16'd4, "halt");
        for (int i = 0; i < 20; i++) begin
            check("halt_flag", bus.halted, 1'b1);
            check("halt_pc", bus.pc, 16'd4);
            @(negedge clk);
        end
        check("halt_ctrl_idle", sample(), IDLE_C);
        do_reset();

        // Asynchronous reset in the middle of an ADD's EXEC cycle.
        start();
        mem[0] = 16'h0152;
        @(negedge clk);
        @(negedge clk);
        check("midexec_before", sample(), mkc(8'h05, 5'd1, 5'd1, 5'd2, 16'h0000, 1'b0));
        #2 reset = 1'b1;
        bus.run = 1'b0;
        #1;
        check("midexec_async_ctrl", sample(), IDLE_C);
        check("midexec_async_pc", bus.pc, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        cur_pc = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_idle", sample(), IDLE_C);
            check("post_reset_pc", bus.pc, 16'h0000);
        end

        // run dropped during DECODE: the instruction completes, then IDLE.
        start();
        mem[0] = 16'h5012;
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        check("runlow_exec", sample(), mkc(8'h05, 5'd0, 5'd0, 5'd16, 16'h0012, 1'b1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("runlow_idle_ctrl", sample(), IDLE_C);
            check("runlow_idle_pc", bus.pc, 16'd1);
        end
        cur_pc = 16'd1;
        start();
        step(16'h51FF, 5'b00000, mkc(8'h05, 5'd1, 5'd1, 5'd16, 16'hFFFF, 1'b1), 16'd2, "resume");

        // Random programs against the reference model.
        do_reset();
        start();
        mfq = 5'b00000;
        for (int i = 0; i < 300; i++) begin
            op    = rand_ops[$urandom_range(0, 10)];
            instr = {op, 4'($urandom), 8'($urandom)};
            if (op == 4'h0) instr[7:4] = rand_ext[$urandom_range(0, 7)];
            fl    = 5'($urandom);
            npc   = ref_next_pc(instr, cur_pc, mfq);
            step(instr, fl, ref_ctrl(instr), npc, "rand");
            if (ref_sets_flags(instr)) mfq = fl;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
